shuffle_cells_iter: RTL and testbench

//  Parametrised, iterated cell-shuffle unit for the Blink datapath. Takes one
//  N_CELLS x CELL_W block over a valid/ready handshake. Applies the cell

---
 rtl/shuffle_cells_pkg.sv | 51 +++++
 rtl/shuffle_cells_step.sv | 26 ++
 rtl/shuffle_cells_iter.sv | 138 +++++++++++++
 tb/tb_shuffle_cells_iter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_cells_pkg.sv
// Shared types, constants and elaboration-time helpers for the iterated cell-shuffle unit.
// Optional build macro used by dependants: SHUFFLE_CELLS_DUAL_EN.
package shuffle_cells_pkg;

    localparam int unsigned IDX_W     = 8;
    localparam int unsigned MAX_CELLS = 256;
    localparam int unsigned TAB_W     = MAX_CELLS * IDX_W;

    // Blink 16-cell permutation, entry 0 leftmost.
    localparam logic [16*IDX_W-1:0] BLINK64_PERM =
        128'h00050b0a_0106040d_020c090f_03070e08;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the first n entries (entry i at [(n-1-i)*IDX_W]) form a bijection on 0..n-1.
    function automatic logic perm_is_bijection(input logic [TAB_W-1:0] perm,
                                               input int unsigned      n);
        logic [MAX_CELLS-1:0] seen;
        logic [IDX_W-1:0]     e;
        logic                 ok;
        seen = '0;
        ok   = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            e = perm[(n-1-i)*IDX_W +: IDX_W];
            if (32'(e) >= n || seen[e]) begin
                ok = 1'b0;
            end else begin
                seen[e] = 1'b1;
            end
        end
        return ok;
    endfunction

    // Inverse index table; entry j sits at [j*IDX_W] (natural order, unlike the input).
    function automatic logic [TAB_W-1:0] perm_inverse(input logic [TAB_W-1:0] perm,
                                                      input int unsigned      n);
        logic [TAB_W-1:0] inv;
        logic [IDX_W-1:0] e;
        inv = '0;
        for (int unsigned i = 0; i < n; i++) begin
            e = perm[(n-1-i)*IDX_W +: IDX_W];
            inv[32'(e)*IDX_W +: IDX_W] = IDX_W'(i);
        end
        return inv;
    endfunction

endpackage

// File: rtl/shuffle_cells_step.sv
// One combinational permutation step: forward (out[i] = in[PERM[i]]) or inverse
// (out[PERM[i]] = in[i]), realised as pure wiring plus a 2:1 mux per cell.
module shuffle_cells_step
    import shuffle_cells_pkg::*;
#(
    parameter int unsigned               N_CELLS = 16,
    parameter int unsigned               CELL_W  = 4,
    parameter logic [N_CELLS*IDX_W-1:0]  PERM    = BLINK64_PERM
) (
    input  logic [N_CELLS*CELL_W-1:0] data_i,
    input  logic                      inv_i,
    output logic [N_CELLS*CELL_W-1:0] data_c_o
);

    localparam logic [TAB_W-1:0] PERM_EXT = TAB_W'(PERM);
    localparam logic [TAB_W-1:0] INV_TAB  = perm_inverse(PERM_EXT, N_CELLS);

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        localparam int unsigned FWD_SRC = 32'(PERM_EXT[(N_CELLS-1-i)*IDX_W +: IDX_W]);
        localparam int unsigned INV_SRC = 32'(INV_TAB[i*IDX_W +: IDX_W]);

        assign data_c_o[i*CELL_W +: CELL_W] = inv_i ? data_i[INV_SRC*CELL_W +: CELL_W]
                                                    : data_i[FWD_SRC*CELL_W +: CELL_W];
    end

endmodule

// File: rtl/shuffle_cells_iter.sv
// Iterated cell-shuffle unit: accepts a block, applies PERM (or its inverse) a
// per-block number of times, returns it. Define SHUFFLE_CELLS_DUAL_EN for two steps per clock.
module shuffle_cells_iter
    import shuffle_cells_pkg::*;
#(
    parameter int unsigned               N_CELLS = 16,
    parameter int unsigned               CELL_W  = 4,
    parameter logic [N_CELLS*IDX_W-1:0]  PERM    = BLINK64_PERM,
    parameter int unsigned               RND_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CELLS*CELL_W-1:0] in_data,
    input  logic                      in_inv,
    input  logic [RND_W-1:0]          in_rounds,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CELLS*CELL_W-1:0] out_data
);

    localparam int unsigned DATA_W = N_CELLS * CELL_W;

    // Elaboration guards: legal cell count and a genuine bijection.
    if (N_CELLS < 2 || N_CELLS > MAX_CELLS) begin : g_bad_cells
        $fatal(1, "shuffle_cells_iter: N_CELLS out of range 2..256");
    end
    if (!perm_is_bijection(TAB_W'(PERM), N_CELLS)) begin : g_bad_perm
        $fatal(1, "shuffle_cells_iter: PERM is not a bijection on 0..N_CELLS-1");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RND_W-1:0]  count_q, count_d;
    logic              inv_q, inv_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] step1_c;

    shuffle_cells_step #(
        .N_CELLS (N_CELLS),
        .CELL_W  (CELL_W),
        .PERM    (PERM)
    ) u_step1 (
        .data_i   (data_q),
        .inv_i    (inv_q),
        .data_c_o (step1_c)
    );

`ifdef SHUFFLE_CELLS_DUAL_EN
    logic [DATA_W-1:0] step2_c;

    shuffle_cells_step #(
        .N_CELLS (N_CELLS),
        .CELL_W  (CELL_W),
        .PERM    (PERM)
    ) u_step2 (
        .data_i   (step1_c),
        .inv_i    (inv_q),
        .data_c_o (step2_c)
    );
`endif

    // Next-state and datapath update; handshake flags are decoded from the next state.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        inv_d   = inv_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    inv_d   = in_inv;
                    count_d = in_rounds;
                    state_d = (in_rounds == '0) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef SHUFFLE_CELLS_DUAL_EN
                if (count_q >= RND_W'(2)) begin
                    data_d  = step2_c;
                    count_d = count_q - RND_W'(2);
                    if (count_q == RND_W'(2)) begin
                        state_d = DONE;
                    end
                end else begin
                    data_d  = step1_c;
                    count_d = count_q - RND_W'(1);
                    state_d = DONE;
                end
`else
                data_d  = step1_c;
                count_d = count_q - RND_W'(1);
                if (count_q == RND_W'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            count_q     <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            count_q     <= count_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_shuffle_cells_iter.sv
// Directed self-checking bench for shuffle_cells_iter (default parameters).
module tb_shuffle_cells_iter;

    localparam logic [63:0] D_ID   = 64'hFEDCBA9876543210;
    localparam logic [63:0] D_F1   = 64'h8E73F9C2D461AB50;
    localparam logic [63:0] D_F2   = 64'h2EDA8C3B71459F60;
    localparam logic [63:0] D_ALT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D_MISC = 64'hDEADBEEFCAFEF00D;

`ifdef SHUFFLE_CELLS_DUAL_EN
    localparam int LAT_R4  = 3;
    localparam int LAT_R5  = 4;
    localparam int LAT_R31 = 17;
`else
    localparam int LAT_R4  = 5;
    localparam int LAT_R5  = 6;
    localparam int LAT_R31 = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_inv = 1'b0;
    logic [4:0]  in_rounds = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [63:0] res;
    int          lat;

    shuffle_cells_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_rounds (in_rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one block, then count clocks (accept edge included) until out_valid.
    task automatic run_block(input logic [63:0] d, input logic inv, input logic [4:0] r,
                             output logic [63:0] result, output int latency);
        @(negedge clk);
        in_data   = d;
        in_inv    = inv;
        in_rounds = r;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_inv    = ~inv;
        in_rounds = 5'd3;
        in_data   = '1;
        latency   = 1;
        while (!out_valid && latency < 64) begin
            @(posedge clk); #1;
            latency++;
        end
        result = out_data;
    endtask

    task automatic drain_check(input string tag);
        @(posedge clk); #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single forward step
        run_block(D_ID, 1'b0, 5'd1, res, lat);
        check("fwd1_data", res, D_F1);
        check("fwd1_lat", 64'(lat), 64'd2);
        drain_check("fwd1_drain");

        // Single inverse step undoes it
        run_block(D_F1, 1'b1, 5'd1, res, lat);
        check("inv1_data", res, D_ID);
        check("inv1_lat", 64'(lat), 64'd2);
        drain_check("inv1_drain");

        // Order 4: four steps are identity in both directions
        run_block(D_ID, 1'b0, 5'd4, res, lat);
        check("fwd4_data", res, D_ID);
        check("fwd4_lat", 64'(lat), 64'(LAT_R4));
        drain_check("fwd4_drain");
        run_block(D_ALT, 1'b1, 5'd4, res, lat);
        check("inv4_data", res, D_ALT);
        drain_check("inv4_drain");

        // Two steps differ from input; inverse of two steps restores it
        run_block(D_ID, 1'b0, 5'd2, res, lat);
        check("fwd2_data", res, D_F2);
        drain_check("fwd2_drain");
        run_block(D_F2, 1'b1, 5'd2, res, lat);
        check("inv2_data", res, D_ID);
        drain_check("inv2_drain");

        // Zero rounds passes data through after one clock
        run_block(D_MISC, 1'b0, 5'd0, res, lat);
        check("r0_data", res, D_MISC);
        check("r0_lat", 64'(lat), 64'd1);
        drain_check("r0_drain");

        // in_valid held high while busy must be ignored, including the drain cycle
        @(negedge clk);
        in_data   = D_ID;
        in_inv    = 1'b0;
        in_rounds = 5'd4;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_data   = 64'h1111111111111111;
        in_rounds = 5'd1;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_data", out_data, D_ID);
        @(posedge clk); #1;
        check("busy_drain_in_ready", 64'(in_ready), 64'd1);
        check("busy_drain_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_idle_in_ready", 64'(in_ready), 64'd1);

        // Backpressure in DONE: outputs hold for 5 clocks
        out_ready = 1'b0;
        run_block(D_ID, 1'b0, 5'd1, res, lat);
        check("bp_data", res, D_F1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", out_data, D_F1);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        drain_check("bp_release");

        // Asynchronous reset in the middle of a long run
        @(negedge clk);
        in_data   = D_ID;
        in_inv    = 1'b0;
        in_rounds = 5'd20;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(D_ID, 1'b0, 5'd1, res, lat);
        check("postrst_data", res, D_F1);
        check("postrst_lat", 64'(lat), 64'd2);
        drain_check("postrst_drain");

        // Odd round count: five steps equal one step
        run_block(D_ID, 1'b0, 5'd5, res, lat);
        check("fwd5_data", res, D_F1);
        check("fwd5_lat", 64'(lat), 64'(LAT_R5));
        drain_check("fwd5_drain");

        // Maximum round count: inverse^31 == forward^1
        run_block(D_ID, 1'b1, 5'd31, res, lat);
        check("inv31_data", res, D_F1);
        check("inv31_lat", 64'(lat), 64'(LAT_R31));
        drain_check("inv31_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
